// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues LDW/STW over a req/ready handshake,
// stalls upstream while an access is outstanding, and registers results toward write-back.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | accepting a new op from EX; ALU/branch ops pass straight through
// S_WAIT | access outstanding, request held from captured operands
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] RESULT,
  input  logic [15:0] MEMDATA,
  input  logic [1:0]  OP_to_MEM,
  input  logic [2:0]  DR_to_MEM,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_READY,
  output logic        STALL,
  output logic        MEM_ERR,
  output logic [15:0] WB_DATA,
  output logic [2:0]  DR_to_WB,
  output logic        WE_to_WB,
  output logic [15:0] MEM_result_forward
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [15:0] cap_result, cap_wdata;
  logic [1:0]  cap_op;
  logic [2:0]  cap_dr;
  logic [15:0] eff_result, eff_wdata;
  logic [1:0]  eff_op;
  logic [2:0]  eff_dr;
  logic        req_raw, stall_raw, err_set, wb_we_nxt;
  logic [15:0] wb_data_nxt;

  // While waiting, drive the memory from the operands captured at issue.
  always_comb begin
    if (state == S_WAIT) begin
      eff_result = cap_result;
      eff_wdata  = cap_wdata;
      eff_op     = cap_op;
      eff_dr     = cap_dr;
    end else begin
      eff_result = RESULT;
      eff_wdata  = MEMDATA;
      eff_op     = OP_to_MEM;
      eff_dr     = DR_to_MEM;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_raw      = 1'b0;
    stall_raw    = 1'b0;
    err_set      = 1'b0;
    wb_we_nxt    = 1'b0;
    wb_data_nxt  = eff_result;
    case (state)
      S_IDLE: begin
        if (!eff_op[1]) begin
          wb_we_nxt = eff_op[0];
        end else begin
          req_raw = 1'b1;
          if (MEM_READY) begin
            if (!eff_op[0]) begin
              wb_data_nxt = MEM_RDATA;
              wb_we_nxt   = 1'b1;
            end
          end else begin
            stall_raw    = 1'b1;
            state_nxt    = S_WAIT;
            wait_cnt_nxt = 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (MEM_READY) begin
          req_raw      = 1'b1;
          state_nxt    = S_IDLE;
          wait_cnt_nxt = 8'd0;
          if (!eff_op[0]) begin
            wb_data_nxt = MEM_RDATA;
            wb_we_nxt   = 1'b1;
          end
        end else if (wait_cnt < MAX_W) begin
          req_raw      = 1'b1;
          stall_raw    = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          // Timeout: drop the request; a load still retires as zero.
          err_set      = 1'b1;
          state_nxt    = S_IDLE;
          wait_cnt_nxt = 8'd0;
          if (!eff_op[0]) begin
            wb_data_nxt = 16'h0000;
            wb_we_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign MEM_ADDR           = {eff_result[15:1], 1'b0};
  assign MEM_WDATA          = eff_wdata;
  assign MEM_REQ            = RESET & req_raw;
  assign MEM_WE             = RESET & req_raw & eff_op[0];
  assign STALL              = RESET & stall_raw;
  assign MEM_result_forward = wb_data_nxt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      wait_cnt   <= 8'd0;
      MEM_ERR    <= 1'b0;
      WB_DATA    <= 16'h0000;
      DR_to_WB   <= 3'd0;
      WE_to_WB   <= 1'b0;
      cap_result <= 16'h0000;
      cap_wdata  <= 16'h0000;
      cap_op     <= 2'b00;
      cap_dr     <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) MEM_ERR <= 1'b1;
      WB_DATA  <= wb_data_nxt;
      DR_to_WB <= eff_dr;
      WE_to_WB <= wb_we_nxt;
      if (state == S_IDLE) begin
        cap_result <= RESULT;
        cap_wdata  <= MEMDATA;
        cap_op     <= OP_to_MEM;
        cap_dr     <= DR_to_MEM;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through ops, zero-wait and stalled accesses,
// timeout abort, reset during an access, and back-to-back loads.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] RESULT, MEMDATA, MEM_RDATA;
  logic [1:0]  OP_to_MEM;
  logic [2:0]  DR_to_MEM;
  logic        MEM_READY;
  logic [15:0] MEM_ADDR, MEM_WDATA, WB_DATA, MEM_result_forward;
  logic        MEM_WE, MEM_REQ, STALL, MEM_ERR, WE_to_WB;
  logic [2:0]  DR_to_WB;

  int n_chk = 0;
  int n_err = 0;
  int stall_cnt;

  mem_stage #(.MAX_WAIT(15)) dut (
    .CLK(CLK), .RESET(RESET), .RESULT(RESULT), .MEMDATA(MEMDATA),
    .OP_to_MEM(OP_to_MEM), .DR_to_MEM(DR_to_MEM), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ),
    .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY), .STALL(STALL),
    .MEM_ERR(MEM_ERR), .WB_DATA(WB_DATA), .DR_to_WB(DR_to_WB),
    .WE_to_WB(WE_to_WB), .MEM_result_forward(MEM_result_forward)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic at_neg;
    @(negedge CLK);
  endtask

  task automatic at_pos;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] res,
                       input logic [15:0] wd, input logic [2:0] dr, input logic rdy);
    OP_to_MEM = op;
    RESULT    = res;
    MEMDATA   = wd;
    DR_to_MEM = dr;
    MEM_READY = rdy;
  endtask

  initial begin
    RESET = 1'b0;
    MEM_RDATA = 16'h0000;
    drive(2'b10, 16'h0000, 16'h0000, 3'd0, 1'b0);
    #12;
    chk("rst_req", {15'd0, MEM_REQ}, 16'd0);
    chk("rst_stall", {15'd0, STALL}, 16'd0);
    chk("rst_wb_data", WB_DATA, 16'h0000);
    chk("rst_wb_we", {15'd0, WE_to_WB}, 16'd0);
    chk("rst_err", {15'd0, MEM_ERR}, 16'd0);

    // ADD pass-through
    drive(2'b01, 16'h1234, 16'h0000, 3'd3, 1'b0);
    at_neg; RESET = 1'b1;
    #1;
    chk("add_stall", {15'd0, STALL}, 16'd0);
    chk("add_req", {15'd0, MEM_REQ}, 16'd0);
    chk("add_fwd", MEM_result_forward, 16'h1234);
    at_pos;
    chk("add_wb_data", WB_DATA, 16'h1234);
    chk("add_wb_dr", {13'd0, DR_to_WB}, 16'd3);
    chk("add_wb_we", {15'd0, WE_to_WB}, 16'd1);

    // BR with stray MEM_READY: no request, no register write
    drive(2'b00, 16'h0055, 16'h0000, 3'd2, 1'b1);
    at_neg;
    chk("br_req", {15'd0, MEM_REQ}, 16'd0);
    chk("br_stall", {15'd0, STALL}, 16'd0);
    at_pos;
    chk("br_wb_data", WB_DATA, 16'h0055);
    chk("br_wb_we", {15'd0, WE_to_WB}, 16'd0);

    // zero-wait LDW
    drive(2'b10, 16'h0041, 16'h0000, 3'd5, 1'b1);
    MEM_RDATA = 16'hBEEF;
    at_neg;
    chk("ld0_addr", MEM_ADDR, 16'h0040);
    chk("ld0_req", {15'd0, MEM_REQ}, 16'd1);
    chk("ld0_we", {15'd0, MEM_WE}, 16'd0);
    chk("ld0_stall", {15'd0, STALL}, 16'd0);
    chk("ld0_fwd", MEM_result_forward, 16'hBEEF);
    at_pos;
    chk("ld0_wb_data", WB_DATA, 16'hBEEF);
    chk("ld0_wb_we", {15'd0, WE_to_WB}, 16'd1);
    chk("ld0_wb_dr", {13'd0, DR_to_WB}, 16'd5);

    // STW with 3 wait cycles; inputs garbled while stalled to test operand hold
    drive(2'b11, 16'h0100, 16'hA5A5, 3'd1, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg;
      if (STALL) stall_cnt++;
      chk("st_req", {15'd0, MEM_REQ}, 16'd1);
      chk("st_we", {15'd0, MEM_WE}, 16'd1);
      chk("st_addr", MEM_ADDR, 16'h0100);
      chk("st_wdata", MEM_WDATA, 16'hA5A5);
      at_pos;
      chk("st_bubble", {15'd0, WE_to_WB}, 16'd0);
      drive(2'b01, 16'hFFFF, 16'h1111, 3'd7, 1'b0);
    end
    drive(2'b11, 16'h0100, 16'hA5A5, 3'd1, 1'b1);
    at_neg;
    chk("st_done_stall", {15'd0, STALL}, 16'd0);
    chk("st_done_req", {15'd0, MEM_REQ}, 16'd1);
    chk("st_done_we", {15'd0, MEM_WE}, 16'd1);
    chk("st_stall_cycles", 16'(stall_cnt), 16'd3);
    at_pos;
    chk("st_wb_we", {15'd0, WE_to_WB}, 16'd0);
    chk("st_wb_data", WB_DATA, 16'h0100);

    // LDW that never completes: timeout after 15 stall cycles
    drive(2'b10, 16'h0200, 16'h0000, 3'd6, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      at_neg;
      if (STALL) stall_cnt++;
      chk("to_req", {15'd0, MEM_REQ}, 16'd1);
      at_pos;
    end
    chk("to_stall_cycles", 16'(stall_cnt), 16'd15);
    chk("to_err_pre", {15'd0, MEM_ERR}, 16'd0);
    at_neg;
    chk("to_abort_req", {15'd0, MEM_REQ}, 16'd0);
    chk("to_abort_stall", {15'd0, STALL}, 16'd0);
    chk("to_abort_fwd", MEM_result_forward, 16'h0000);
    at_pos;
    chk("to_err", {15'd0, MEM_ERR}, 16'd1);
    chk("to_wb_data", WB_DATA, 16'h0000);
    chk("to_wb_we", {15'd0, WE_to_WB}, 16'd1);
    chk("to_wb_dr", {13'd0, DR_to_WB}, 16'd6);
    drive(2'b01, 16'h0022, 16'h0000, 3'd2, 1'b0);
    at_pos;
    chk("to_err_sticky", {15'd0, MEM_ERR}, 16'd1);
    chk("to_next_add", WB_DATA, 16'h0022);

    // reset two cycles into a LDW wait
    drive(2'b10, 16'h0300, 16'h0000, 3'd4, 1'b0);
    at_pos;
    at_pos;
    chk("rw_req_pre", {15'd0, MEM_REQ}, 16'd1);
    chk("rw_stall_pre", {15'd0, STALL}, 16'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rw_req", {15'd0, MEM_REQ}, 16'd0);
    chk("rw_stall", {15'd0, STALL}, 16'd0);
    chk("rw_wb_data", WB_DATA, 16'h0000);
    chk("rw_wb_dr", {13'd0, DR_to_WB}, 16'd0);
    chk("rw_wb_we", {15'd0, WE_to_WB}, 16'd0);
    chk("rw_err", {15'd0, MEM_ERR}, 16'd0);
    drive(2'b00, 16'h0777, 16'h0000, 3'd1, 1'b1);
    MEM_RDATA = 16'hDEAD;
    at_pos;
    #2 RESET = 1'b1;
    at_neg;
    chk("rw_late_req", {15'd0, MEM_REQ}, 16'd0);
    chk("rw_late_stall", {15'd0, STALL}, 16'd0);
    at_pos;
    chk("rw_late_wb_data", WB_DATA, 16'h0777);
    chk("rw_late_wb_we", {15'd0, WE_to_WB}, 16'd0);
    drive(2'b01, 16'h0010, 16'h0000, 3'd1, 1'b0);
    at_neg;
    chk("rw_idle_req", {15'd0, MEM_REQ}, 16'd0);
    at_pos;
    chk("rw_idle_wb_we", {15'd0, WE_to_WB}, 16'd1);
    chk("rw_idle_wb_data", WB_DATA, 16'h0010);

    // back-to-back LDW (ready after 1 wait cycle each) then ADD
    drive(2'b10, 16'h0400, 16'h0000, 3'd4, 1'b0);
    MEM_RDATA = 16'h1111;
    at_pos;
    chk("bb1_bubble", {15'd0, WE_to_WB}, 16'd0);
    MEM_READY = 1'b1;
    MEM_RDATA = 16'hCAFE;
    at_neg;
    chk("bb1_stall", {15'd0, STALL}, 16'd0);
    chk("bb1_fwd", MEM_result_forward, 16'hCAFE);
    at_pos;
    chk("bb1_wb_data", WB_DATA, 16'hCAFE);
    chk("bb1_wb_we", {15'd0, WE_to_WB}, 16'd1);
    chk("bb1_wb_dr", {13'd0, DR_to_WB}, 16'd4);
    drive(2'b10, 16'h0402, 16'h0000, 3'd7, 1'b0);
    at_pos;
    chk("bb2_bubble", {15'd0, WE_to_WB}, 16'd0);
    MEM_READY = 1'b1;
    MEM_RDATA = 16'h4242;
    at_pos;
    chk("bb2_wb_data", WB_DATA, 16'h4242);
    chk("bb2_wb_dr", {13'd0, DR_to_WB}, 16'd7);
    chk("bb2_wb_we", {15'd0, WE_to_WB}, 16'd1);
    drive(2'b01, 16'h0099, 16'h0000, 3'd2, 1'b0);
    at_neg;
    chk("bb_add_stall", {15'd0, STALL}, 16'd0);
    at_pos;
    chk("bb_add_wb_data", WB_DATA, 16'h0099);
    chk("bb_add_wb_dr", {13'd0, DR_to_WB}, 16'd2);
    chk("bb_add_wb_we", {15'd0, WE_to_WB}, 16'd1);
    drive(2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);
    at_pos;
    chk("bb_no_dup", {15'd0, WE_to_WB}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of write-back.
- Consumes the EX pipeline register (result, store data, 2-bit op, destination register). Performs LDW/STW against an external data memory through a variable-latency req/ready handshake.
- Stalls the front of the pipeline while an access is outstanding. Registers result, destination and write-enable toward write-back.

Parameters:
- MAX_WAIT, 15, cycles a request may wait for MEM_READY before it is aborted; legal range 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (asserted when 0).
- RESULT  in  16  EX result: ALU sum, branch target, or byte address for LDW/STW.
- MEMDATA  in  16  store data from EX.
- OP_to_MEM  in  2  op code: 00 BR, 01 ADD, 10 LDW, 11 STW.
- DR_to_MEM  in  3  destination register.
- MEM_ADDR  out  16  data-memory address.
- MEM_WDATA  out  16  data-memory write data.
- MEM_WE  out  1  1 = write, 0 = read; meaningful only while MEM_REQ = 1.
- MEM_REQ  out  1  access request.
- MEM_RDATA  in  16  read data; valid in the cycle MEM_READY = 1.
- MEM_READY  in  1  access complete.
- STALL  out  1  upstream stages must hold their registers this cycle.
- MEM_ERR  out  1  sticky timeout flag.
- WB_DATA  out  16  registered value for write-back.
- DR_to_WB  out  3  registered destination.
- WE_to_WB  out  1  registered register-file write enable.
- MEM_result_forward  out  16  combinational forwarding value, equal to the next WB_DATA.

Behaviour:
- Reset (RESET = 0, async):
  - state = IDLE, wait counter = 0, MEM_ERR = 0.
  - WB_DATA = 0, DR_to_WB = 0, WE_to_WB = 0.
  - MEM_REQ, MEM_WE and STALL forced 0 combinationally.
  - Reset mid-access drops the request immediately. A late MEM_READY after reset is ignored.
- Address and data:
  - MEM_ADDR = {RESULT[15:1], 1'b0}; word aligned, bit 0 discarded.
  - MEM_WDATA = MEMDATA.
  - MEM_WE = OP_to_MEM[0] when OP_to_MEM[1] = 1.
- State IDLE:
  - Op 00 or 01: no request.
    - Next edge: WB_DATA <= RESULT, DR_to_WB <= DR_to_MEM.
    - WE_to_WB <= 1 for 01, 0 for 00.
    - Latency 1 cycle.
  - Op 1x: MEM_REQ = 1 combinationally.
    - If MEM_READY = 1 in the same cycle: zero-wait completion, STALL = 0, state stays IDLE.
      - LDW: WB_DATA <= MEM_RDATA, WE_to_WB <= 1.
      - STW: WB_DATA <= RESULT, WE_to_WB <= 0.
    - Else: STALL = 1, next state WAIT, counter <= 1, WE_to_WB <= 0 (bubble).
- State WAIT:
  - MEM_REQ = 1. MEM_ADDR, MEM_WDATA and MEM_WE are held stable from the captured inputs; upstream is frozen by STALL.
  - MEM_READY = 1: STALL = 0 this cycle. Commit as in the IDLE zero-wait case. Next state IDLE, counter <= 0.
  - MEM_READY = 0 and counter < MAX_WAIT: STALL = 1, counter <= counter + 1, bubble to WB.
  - MEM_READY = 0 and counter == MAX_WAIT: abort.
    - MEM_REQ = 0 that cycle, STALL = 0, MEM_ERR <= 1 (sticky until reset).
    - LDW commits WB_DATA <= 0x0000 with WE_to_WB <= 1. STW commits nothing (WE_to_WB <= 0).
    - Next state IDLE.
- Counter width is 8 bits. The counter never wraps, because abort occurs at MAX_WAIT.
- MEM_READY while MEM_REQ = 0 is ignored.
- MEM_result_forward:
  - RESULT for op 0x.
  - MEM_RDATA for LDW on its completing cycle.
  - 0 on LDW abort.
  - RESULT otherwise.
- STALL is purely combinational from state, op, MEM_READY and counter. Never asserted for BR/ADD.

Test Plan:
- Reset release, op 01, RESULT = 0x1234, DR = 3 -> next edge WB_DATA = 0x1234, DR_to_WB = 3, WE_to_WB = 1, STALL never high.
- LDW, RESULT = 0x0041, MEM_READY tied 1, MEM_RDATA = 0xBEEF, DR = 5 -> MEM_ADDR = 0x0040, MEM_WE = 0, STALL = 0, next edge WB_DATA = 0xBEEF, WE_to_WB = 1, DR_to_WB = 5.
- STW, RESULT = 0x0100, MEMDATA = 0xA5A5, MEM_READY after 3 wait cycles -> STALL high exactly 3 cycles, MEM_WE = 1, address/data stable throughout, 3 bubbles (WE_to_WB = 0), completion WE_to_WB = 0.
- LDW with MEM_READY never asserted, MAX_WAIT = 15 -> STALL high 15 cycles, abort cycle MEM_REQ = 0, MEM_ERR = 1 thereafter, WB_DATA = 0x0000, WE_to_WB = 1.
- LDW in WAIT (2 cycles in), RESET pulsed low -> MEM_REQ/STALL drop asynchronously, all WB outputs 0. After release, an asserted MEM_READY has no effect, state IDLE.
- Back-to-back LDW (ready after 1 cycle) then ADD -> ADD result reaches WB one cycle after the load commits, no lost or duplicated write.
